ro_freq_compare: RTL



---
 rtl/ro_pkg.sv | 24 ++
 rtl/ro_freq_compare_if.sv | 30 +++
 rtl/ro_edge_counter.sv | 53 +++++
 rtl/ro_freq_compare.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared constants, FSM state type and small helpers for the RO frequency comparator.
package ro_pkg;

    localparam int RO_BANK_SIZE      = 32;
    localparam int SEL_W             = 5;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_WIN_W         = 16;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_SYNC_STAGES   = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_COUNT   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } ro_state_e;

    // The oscillators run only while settling and counting.
    function automatic logic ro_running(input ro_state_e s);
        return (s == ST_ARM) || (s == ST_COUNT);
    endfunction

endpackage

// File: rtl/ro_freq_compare_if.sv
// Request/response bundle between a measurement requester and ro_freq_compare.
interface ro_freq_compare_if
    import ro_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) ();

    logic             start;
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel2;
    logic [WIN_W-1:0] window_len;
    logic             busy;
    logic             done;
    logic             resp;
    logic             tie;
    logic [CNT_W-1:0] count1;
    logic [CNT_W-1:0] count2;

    modport master (
        output start, sel1, sel2, window_len,
        input  busy, done, resp, tie, count1, count2
    );

    modport slave (
        input  start, sel1, sel2, window_len,
        output busy, done, resp, tie, count1, count2
    );

endinterface

// File: rtl/ro_edge_counter.sv
// Synchronizes one asynchronous RO output, detects rising edges and counts them
// with saturation while count_en is high.
module ro_edge_counter
    import ro_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ro,
    input  logic             i_clear,
    input  logic             i_count_en,
    output logic [CNT_W-1:0] o_count
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_qq;
    logic [CNT_W-1:0]       r_count;
    logic                   w_rise;
    logic                   w_at_max;

    // Synchronizer chain plus one extra stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_sync_qq <= 1'b0;
        end else begin
            r_sync[0] <= i_ro;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_sync_qq <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise   = r_sync[SYNC_STAGES-1] & ~r_sync_qq;
    assign w_at_max = &r_count;

    // Saturating edge counter; holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && w_rise && !w_at_max) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ro_freq_compare.sv
// Readout end of the RO PUF array: enables both banks, counts edges of one
// selected RO per bank over a window and reports which one ran faster.
module ro_freq_compare
    import ro_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int WIN_W         = DEF_WIN_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    rst,
    ro_freq_compare_if.slave        bus,
    input  logic [RO_BANK_SIZE-1:0] ro1_in,
    input  logic [RO_BANK_SIZE-1:0] ro2_in,
    output logic                    ro_activate_1,
    output logic                    ro_activate_2
);

    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);

    ro_state_e        r_state;
    ro_state_e        w_next;
    logic [WIN_W-1:0] r_timer;
    logic [WIN_W-1:0] r_win;
    logic [SEL_W-1:0] r_sel1;
    logic [SEL_W-1:0] r_sel2;
    logic             w_accept;
    logic             w_timer_clr;
    logic             w_count_en;
    logic             w_ro1;
    logic             w_ro2;
    logic [CNT_W-1:0] w_cnt1;
    logic [CNT_W-1:0] w_cnt2;
    logic             r_act;
    logic             r_busy;
    logic             r_done;
    logic             r_resp;
    logic             r_tie;
    logic [CNT_W-1:0] r_count1;
    logic [CNT_W-1:0] r_count2;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a zero-length window skips COUNT entirely.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next   = ST_ARM;
                    w_accept = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (r_timer == SETTLE_LAST) begin
                    if (r_win == '0) begin
                        w_next = ST_COMPARE;
                    end else begin
                        w_next = ST_COUNT;
                    end
                end else begin
                    w_next = ST_ARM;
                end
            end
            ST_COUNT: begin
                if (r_timer == (r_win - WIN_W'(1))) begin
                    w_next = ST_COMPARE;
                end else begin
                    w_next = ST_COUNT;
                end
            end
            ST_COMPARE: w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // The timer counts cycles spent in the current state.
    assign w_timer_clr = (w_next != r_state) || (r_state == ST_IDLE);
    assign w_count_en  = (r_state == ST_COUNT);

    // Cycle timer shared by the settle phase and the count window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_timer_clr) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + WIN_W'(1);
        end
    end

    // Challenge parameters are captured once so the mux is stable all run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel1 <= '0;
            r_sel2 <= '0;
            r_win  <= '0;
        end else if (w_accept) begin
            r_sel1 <= bus.sel1;
            r_sel2 <= bus.sel2;
            r_win  <= bus.window_len;
        end
    end

    assign w_ro1 = ro1_in[r_sel1];
    assign w_ro2 = ro2_in[r_sel2];

    ro_edge_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt1 (
        .clk        (clk),
        .rst        (rst),
        .i_ro       (w_ro1),
        .i_clear    (w_accept),
        .i_count_en (w_count_en),
        .o_count    (w_cnt1)
    );

    ro_edge_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt2 (
        .clk        (clk),
        .rst        (rst),
        .i_ro       (w_ro2),
        .i_clear    (w_accept),
        .i_count_en (w_count_en),
        .o_count    (w_cnt2)
    );

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_act  <= ro_running(w_next);
            r_busy <= (w_next != ST_IDLE);
            r_done <= (w_next == ST_DONE);
        end
    end

    // Results are captured in COMPARE and held until the next comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count1 <= '0;
            r_count2 <= '0;
            r_resp   <= 1'b0;
            r_tie    <= 1'b0;
        end else if (r_state == ST_COMPARE) begin
            r_count1 <= w_cnt1;
            r_count2 <= w_cnt2;
            r_resp   <= (w_cnt1 > w_cnt2);
            r_tie    <= (w_cnt1 == w_cnt2);
        end
    end

    assign ro_activate_1 = r_act;
    assign ro_activate_2 = r_act;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.resp      = r_resp;
    assign bus.tie       = r_tie;
    assign bus.count1    = r_count1;
    assign bus.count2    = r_count2;

endmodule
